// File: rtl/difftest_uart_in_responder.sv
// difftest_uart_in_responder
//   Answers DUT getc requests on the difftest UART-input interface with
//   characters queued by the simulation host.
//   - The host loads characters through a valid/ready push port.
//   - Requests are answered from a small FIFO with zero latency.
//   - 8'hff is returned whenever the FIFO is empty.
//   Optional feature macro: UART_IN_ECHO_EN
//   - When defined, every served character is echoed one cycle later.
//   - When undefined, echo_valid and echo_ch are tied to zero.
module difftest_uart_in_responder #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       difftest_uart_in_valid,
  output logic [7:0]                 difftest_uart_in_ch,
  input  logic                       host_push_valid,
  input  logic [7:0]                 host_push_ch,
  output logic                       host_push_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       miss_count,
  output logic [CNT_WIDTH-1:0]       served_count,
  output logic                       echo_valid,
  output logic [7:0]                 echo_ch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]          mem [DEPTH];
  logic [AW:0]         rd_ptr;
  logic [AW:0]         wr_ptr;
  logic                empty;
  logic                full;
  logic                pop;
  logic                miss;
  logic                push;

  // Occupancy and handshake decode; the pointer MSB separates full from empty
  always_comb begin
    fifo_level          = wr_ptr - rd_ptr;
    empty               = (fifo_level == '0);
    full                = (fifo_level == FULL_LEVEL);
    host_push_ready     = reset && !full;
    pop                 = difftest_uart_in_valid && !empty;
    miss                = difftest_uart_in_valid && empty;
    push                = host_push_valid && host_push_ready;
    difftest_uart_in_ch = empty ? 8'hff : mem[rd_ptr[AW-1:0]];
  end

  // Character storage; contents need no reset because the pointers gate reads
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= host_push_ch;
    end
  end

  // Read and write pointers; a reset discards everything still buffered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
    end
  end

  // Request statistics, saturating at all-ones rather than wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_count   <= '0;
      served_count <= '0;
    end else begin
      if (miss && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
      if (pop && (served_count != '1)) begin
        served_count <= served_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef UART_IN_ECHO_EN
  // Echo each served character one cycle after it was handed to the DUT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_valid <= 1'b0;
      echo_ch    <= 8'h00;
    end else begin
      echo_valid <= pop;
      if (pop) begin
        echo_ch <= difftest_uart_in_ch;
      end
    end
  end
`else
  // Echo disabled: keep the ports but drive them constant
  always_comb begin
    echo_valid = 1'b0;
    echo_ch    = 8'h00;
  end
`endif

endmodule

// File: tb/tb_difftest_uart_in_responder.sv
// tb_difftest_uart_in_responder
//   Directed test of the UART-input responder with hand-computed expectations.
//   A narrow counter width is used so that saturation is reachable quickly.
module tb_difftest_uart_in_responder;

  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 8;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   difftest_uart_in_valid;
  logic [7:0]             difftest_uart_in_ch;
  logic                   host_push_valid;
  logic [7:0]             host_push_ch;
  logic                   host_push_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_WIDTH-1:0]   miss_count;
  logic [CNT_WIDTH-1:0]   served_count;
  logic                   echo_valid;
  logic [7:0]             echo_ch;

  int errors = 0;
  int checks = 0;

  difftest_uart_in_responder #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .difftest_uart_in_valid (difftest_uart_in_valid),
    .difftest_uart_in_ch    (difftest_uart_in_ch),
    .host_push_valid        (host_push_valid),
    .host_push_ch           (host_push_ch),
    .host_push_ready        (host_push_ready),
    .fifo_level             (fifo_level),
    .miss_count             (miss_count),
    .served_count           (served_count),
    .echo_valid             (echo_valid),
    .echo_ch                (echo_ch)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive the request and push inputs for the coming cycle
  task automatic applyStimulus(input logic getc, input logic push, input logic [7:0] ch);
    difftest_uart_in_valid = getc;
    host_push_valid        = push;
    host_push_ch           = ch;
  endtask

  // Advance one clock edge and settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Directed scenarios
  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #12;
    checkOutput("rst_ch",     32'(difftest_uart_in_ch), 'hff);
    checkOutput("rst_level",  32'(fifo_level), 0);
    checkOutput("rst_miss",   32'(miss_count), 0);
    checkOutput("rst_served", 32'(served_count), 0);
    checkOutput("rst_ready",  32'(host_push_ready), 0);
    checkOutput("rst_echo_v", 32'(echo_valid), 0);
    checkOutput("rst_echo_c", 32'(echo_ch), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(host_push_ready), 1);

    // Three getc cycles on an empty FIFO are three misses
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_ch", 32'(difftest_uart_in_ch), 'hff);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t1_miss",   32'(miss_count), 3);
    checkOutput("t1_served", 32'(served_count), 0);
    checkOutput("t1_level",  32'(fifo_level), 0);

    // Push A, B, C then read them back in order
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h41 + i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t2_level3", 32'(fifo_level), 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("t2_ch", 32'(difftest_uart_in_ch), 'h41 + i);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t2_served", 32'(served_count), 3);
    checkOutput("t2_level0", 32'(fifo_level), 0);
    checkOutput("t2_miss",   32'(miss_count), 3);

    // Fill to DEPTH, hold the 17th, then pop while full
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h60 + i));
      if (i == 0 || i == DEPTH - 1) checkOutput("t3_ready_fill", 32'(host_push_ready), 1);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 8'h70);
    checkOutput("t3_full_level", 32'(fifo_level), 16);
    checkOutput("t3_full_ready", 32'(host_push_ready), 0);
    tick();
    checkOutput("t3_held_level", 32'(fifo_level), 16);
    applyStimulus(1'b1, 1'b1, 8'h70);
    checkOutput("t3_full_ready2", 32'(host_push_ready), 0);
    checkOutput("t3_full_ch",     32'(difftest_uart_in_ch), 'h60);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h70);
    checkOutput("t3_pop_level", 32'(fifo_level), 15);
    checkOutput("t3_ready_back", 32'(host_push_ready), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t3_refill_level", 32'(fifo_level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("t3_drain_ch", 32'(difftest_uart_in_ch), 'h61 + i);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t3_served", 32'(served_count), 20);
    checkOutput("t3_level0", 32'(fifo_level), 0);

    // Empty FIFO, push and getc together: no bypass
    applyStimulus(1'b1, 1'b1, 8'h78);
    checkOutput("t4_ch_nobypass", 32'(difftest_uart_in_ch), 'hff);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t4_level", 32'(fifo_level), 1);
    checkOutput("t4_miss",  32'(miss_count), 4);
    checkOutput("t4_ch",    32'(difftest_uart_in_ch), 'h78);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t4_served", 32'(served_count), 21);

    // Mid-level push and pop together leave the level unchanged
    applyStimulus(1'b0, 1'b1, 8'h31);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h32);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h33);
    checkOutput("mid_ch", 32'(difftest_uart_in_ch), 'h31);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("mid_level", 32'(fifo_level), 2);
    checkOutput("mid_next_ch", 32'(difftest_uart_in_ch), 'h32);

    // Level 5, then an asynchronous reset pulse between edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h50 + i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t5_level5", 32'(fifo_level), 5);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t5_level",  32'(fifo_level), 0);
    checkOutput("t5_miss",   32'(miss_count), 0);
    checkOutput("t5_served", 32'(served_count), 0);
    checkOutput("t5_ch",     32'(difftest_uart_in_ch), 'hff);
    checkOutput("t5_ready",  32'(host_push_ready), 0);
    #1;
    reset = 1'b1;
    tick();

    // Echo of a served character and silence after a miss
    applyStimulus(1'b0, 1'b1, 8'h5a);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t6_ch", 32'(difftest_uart_in_ch), 'h5a);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
`ifdef UART_IN_ECHO_EN
    checkOutput("t6_echo_v", 32'(echo_valid), 1);
    checkOutput("t6_echo_c", 32'(echo_ch), 'h5a);
`else
    checkOutput("t6_echo_v_off", 32'(echo_valid), 0);
    checkOutput("t6_echo_c_off", 32'(echo_ch), 0);
`endif
    tick();
    checkOutput("t6_echo_idle", 32'(echo_valid), 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t6_miss_noecho", 32'(echo_valid), 0);
    checkOutput("t6_miss", 32'(miss_count), 1);
    checkOutput("t6_served", 32'(served_count), 1);

    // Miss counter saturates at all-ones
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 260; i++) begin
      tick();
    end
    checkOutput("sat_miss", 32'(miss_count), 255);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("sat_miss_hold", 32'(miss_count), 255);
    checkOutput("sat_served", 32'(served_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
